fadd_issue_arbiter: RTL and testbench
=====================================

Name: fadd_issue_arbiter

Overview:
Shares one pipelined fadd unit (3-cycle, no reset, free-running) between NREQ requesters.
- Grants round-robin, at most one operation issued per cycle.
- Tracks in-flight operations with its own tag pipeline and returns each result to the issuing requester's holding register.
- Each requester has at most one outstanding operation, so the FPU pipeline never needs back-pressure.

Parameters:
NREQ, 2, number of requesters (2..8)
LAT, 3, fadd issue-to-result latency in clock edges; must equal the fadd pipeline depth
IDW, $clog2(NREQ), requester-id width (derived, not overridable)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  NREQ  requester i has an operation
req_a  in  NREQ*32  operand a, slice i
req_b  in  NREQ*32  operand b, slice i
req_ready  out  NREQ  one-hot grant; transfer when valid&ready
rsp_valid  out  NREQ  result held for requester i
rsp_data  out  NREQ*32  result, slice i
rsp_ack  in  NREQ  requester i consumes its result
fadd_a  out  32  to fadd a
fadd_b  out  32  to fadd b
fadd_en  out  1  to fadd en
fadd_c  in  32  from fadd c
fadd_ready  in  1  from fadd ready (checked only)

Behaviour:
- Reset (async, rstn=0):
  - All per-requester FSMs go to IDLE; rsp_valid=0, rsp_data=0.
  - Tag pipeline valid bits are cleared; the round-robin pointer is set to requester NREQ-1, so requester 0 has first priority.
  - fadd_en=0.
- Per-requester FSM:
  - IDLE → INFLIGHT on a grant.
  - INFLIGHT → DONE when its tag emerges from the tag pipe.
  - DONE → IDLE on rsp_ack.
- Eligibility: requester i is eligible iff req_valid[i] and state is IDLE.
- Grant:
  - Combinational, one-hot among eligible requesters.
  - Search starts at pointer+1, wrapping modulo NREQ.
  - The pointer updates to the granted id on the clock edge.
- Issue:
  - In the grant cycle, fadd_a/fadd_b are driven combinationally from the granted slice and fadd_en=1.
  - With no grant, fadd_en=0 and fadd_a/fadd_b=0.
- Tag pipe: LAT-deep shift register of {valid, id}, loaded with {grant_any, grant_id} every cycle.
- Capture:
  - When the tail is valid, fadd_c is written to rsp_data[id] on that edge and the FSM for id goes to DONE.
  - rsp_valid[id] rises 4 cycles after the grant cycle (issue at cycle t, c valid during t+3, rsp_valid in t+4).
- Throughput: one issue per cycle across requesters; per requester, at most one issue per 5 cycles (grant, 3 in flight, DONE ≥1 cycle).
- Same-cycle ack and req_valid: the requester is not eligible that cycle; it may be granted from the next cycle.
- rsp_ack while not DONE is ignored. rsp_data[i] holds its value until overwritten by the next capture.
- Reset mid-operation:
  - In-flight results are discarded.
  - Stale fadd_ready/fadd_c pulses after reset are ignored, because capture uses only the internal tag pipe.
- Check: the simulation-only assertion "tail.valid == fadd_ready" holds from LAT cycles after reset release.
- No FP arithmetic is performed here; operands pass through unmodified, except as described under the optional feature.

Optional Feature:
FADD_ARB_FSUB_EN
- Defined:
  - Adds input port req_op[NREQ]: 0 = add, 1 = subtract.
  - For a subtract, fadd_b = {~b[31], b[30:0]}.
- Undefined: req_op is absent and all operations are additions.

Decomposition:
- Package fadd_arb_pkg:
  - FP_W=32, FADD_LAT=3.
  - Enum req_state_t {IDLE, INFLIGHT, DONE}.
  - Struct tag_t {valid, id}.
- Sub-module rr_arbiter (NREQ): req vector in, one-hot grant plus id out, pointer register with async reset inside.

Test Plan:
1. Req0 with a=0x3F800000, b=0x40000000 at cycle t → fadd_en=1 at t; rsp_valid[0]=1 at t+4 with rsp_data[0]=0x40400000; hold until ack, then IDLE.
2. Req0 and req1 valid together, continuously re-requesting after each ack → grants alternate 0,1,0,1; no requester is granted twice while the other is eligible.
3. Back-to-back issues from req0 (cycle t) and req1 (cycle t+1) → captures at consecutive edges into the correct slices; no cross-contamination.
4. Requester 0 in DONE with req_valid=1 but no ack for 10 cycles → never granted; req1 is still served.
5. rstn pulsed low while 2 ops are in flight → rsp_valid stays 0 after release; the late fadd_ready pulse does not set rsp_valid; next grant goes to requester 0.
6. FADD_ARB_FSUB_EN: a=0x40400000, b=0x3F800000, op=1 → rsp_data=0x40000000.

Source files
------------

// File: rtl/fadd_arb_pkg.sv
// Shared types and constants for the fadd issue arbiter.
package fadd_arb_pkg;

    localparam int FP_W     = 32;
    localparam int FADD_LAT = 3;
    // Tag id field is sized for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        INFLIGHT,
        DONE
    } req_state_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    // Flip the sign bit: a - b is issued to the adder as a + (-b).
    function automatic logic [FP_W-1:0] fp_negate(input logic [FP_W-1:0] x);
        return {~x[FP_W-1], x[FP_W-2:0]};
    endfunction

endpackage

// File: rtl/fadd_issue_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, search starting
// just after the last granted id. The pointer resets to NREQ-1 so that
// requester 0 has first priority after reset.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] gnt_id_o,
    output logic                    gnt_any_o
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0] ptr_q, ptr_d;

    // Scan offsets 1..NREQ from the pointer; first requesting slot wins.
    always_comb begin
        int idx;
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_any_o = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!gnt_any_o && (idx == i) && req_i[i]) begin
                    gnt_any_o = 1'b1;
                    gnt_o[i]  = 1'b1;
                    gnt_id_o  = IDW'(i);
                end
            end
        end
        ptr_d = gnt_any_o ? gnt_id_o : ptr_q;
    end

    // Pointer register: remembers the last granted requester.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= IDW'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fadd_issue_arbiter.sv
// Shares one free-running pipelined fadd unit between NREQ requesters.
// Issues at most one op per cycle (round-robin), tracks in-flight ops in
// a private tag pipe and captures each result into the issuer's slot.
// Optional build macro: FADD_ARB_FSUB_EN adds req_op (1 = subtract).
//
// Per-requester FSM:
//   state    | meaning
//   IDLE     | no outstanding op; eligible when req_valid is high
//   INFLIGHT | op issued, result still travelling down the fadd pipe
//   DONE     | result held in rsp_data; waits for rsp_ack
module fadd_issue_arbiter
    import fadd_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int LAT  = FADD_LAT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*FP_W-1:0] req_a,
    input  logic [NREQ*FP_W-1:0] req_b,
`ifdef FADD_ARB_FSUB_EN
    input  logic [NREQ-1:0]      req_op,
`endif
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [NREQ*FP_W-1:0] rsp_data,
    input  logic [NREQ-1:0]      rsp_ack,
    output logic [FP_W-1:0]      fadd_a,
    output logic [FP_W-1:0]      fadd_b,
    output logic                 fadd_en,
    input  logic [FP_W-1:0]      fadd_c,
    input  logic                 fadd_ready
);

    localparam int IDW = $clog2(NREQ);

    req_state_t       state_q [NREQ];
    req_state_t       state_d [NREQ];
    logic [FP_W-1:0]  data_q  [NREQ];
    tag_t             pipe_q  [LAT];
    tag_t             tail;

    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_id;
    logic             grant_any;

    assign tail = pipe_q[LAT-1];

    // Only idle requesters compete; nothing is granted while reset is held.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = rstn && req_valid[i] && (state_q[i] == IDLE);
        end
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk       (clk),
        .rstn      (rstn),
        .req_i     (elig),
        .gnt_o     (grant),
        .gnt_id_o  (grant_id),
        .gnt_any_o (grant_any)
    );

    assign req_ready = grant;
    assign fadd_en   = grant_any;

    // Route the granted operands to the adder; zeros when idle.
    always_comb begin
        fadd_a = '0;
        fadd_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                fadd_a = req_a[i*FP_W +: FP_W];
`ifdef FADD_ARB_FSUB_EN
                fadd_b = req_op[i] ? fp_negate(req_b[i*FP_W +: FP_W])
                                   : req_b[i*FP_W +: FP_W];
`else
                fadd_b = req_b[i*FP_W +: FP_W];
`endif
            end
        end
    end

    // Tag pipe mirrors the adder's depth so the tail names the result owner.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < LAT; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q[0] <= '{valid: grant_any, id: TAG_ID_W'(grant_id)};
            for (int k = 1; k < LAT; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    // Per-requester next-state logic.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE: begin
                    if (grant[i]) begin
                        state_d[i] = INFLIGHT;
                    end
                end
                INFLIGHT: begin
                    if (tail.valid && (tail.id == TAG_ID_W'(i))) begin
                        state_d[i] = DONE;
                    end
                end
                DONE: begin
                    if (rsp_ack[i]) begin
                        state_d[i] = IDLE;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // State registers and result capture from the pipe tail.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREQ; i++) begin
                state_q[i] <= IDLE;
                data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                state_q[i] <= state_d[i];
                if (tail.valid && (tail.id == TAG_ID_W'(i))) begin
                    data_q[i] <= fadd_c;
                end
            end
        end
    end

    // Flatten per-requester response state onto the output buses.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i]                = (state_q[i] == DONE);
            rsp_data[i*FP_W +: FP_W]    = data_q[i];
        end
    end

`ifndef SYNTHESIS
    logic [7:0] settle_q;

    // Once the pipe holds only post-reset issues, the adder's ready must
    // line up with our tail; earlier pulses may be leftovers from before reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            settle_q <= '0;
        end else if (settle_q != 8'(LAT)) begin
            settle_q <= settle_q + 8'd1;
        end else begin
            assert (tail.valid == fadd_ready);
        end
    end
`endif

endmodule

// File: tb/tb_fadd_issue_arbiter.sv
module tb_fadd_issue_arbiter;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [N*32-1:0] rsp_data;
    logic [N-1:0]   rsp_ack = '0;
    logic [31:0]    fadd_a, fadd_b, fadd_c;
    logic           fadd_en, fadd_ready;
`ifdef FADD_ARB_FSUB_EN
    logic [N-1:0]   req_op = '0;
`endif

    always #5 clk = ~clk;

    fadd_issue_arbiter #(.NREQ(N)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
`ifdef FADD_ARB_FSUB_EN
        .req_op     (req_op),
`endif
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_ack    (rsp_ack),
        .fadd_a     (fadd_a),
        .fadd_b     (fadd_b),
        .fadd_en    (fadd_en),
        .fadd_c     (fadd_c),
        .fadd_ready (fadd_ready)
    );

    // ---------------- single-precision add via double arithmetic --------
    function automatic real f2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) d = {x[31], 63'b0};
        else d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52];
        if (e < 11'd897) return {d[63], 31'b0};
        if (e > 11'd1150) return {d[63], 8'hFF, 23'b0};
        return {d[63], 8'(e - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] f32_add(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom), 8'($urandom_range(134, 120)), 23'($urandom)};
    endfunction

    // ---------------- free-running 3-stage adder, no reset ---------------
    logic [31:0] pa [3] = '{32'd0, 32'd0, 32'd0};
    logic [31:0] pb [3] = '{32'd0, 32'd0, 32'd0};
    logic        pe [3] = '{1'b0, 1'b0, 1'b0};

    always @(posedge clk) begin
        pe[0] <= fadd_en; pa[0] <= fadd_a; pb[0] <= fadd_b;
        pe[1] <= pe[0];   pa[1] <= pa[0];  pb[1] <= pb[0];
        pe[2] <= pe[1];   pa[2] <= pa[1];  pb[2] <= pb[1];
    end

    assign fadd_c     = f32_add(pa[2], pb[2]);
    assign fadd_ready = pe[2];

    // ---------------- reference model -------------------------------------
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          m_busy     [N];
    int          m_ready_at [N];
    logic [31:0] m_res      [N];
    logic [31:0] m_data     [N];
    int          m_last;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0;
            m_data[i] = '0;
            m_ready_at[i] = 0;
            m_res[i] = '0;
        end
        m_last = N - 1;
    endtask

    // Called at a negedge once inputs are driven; checks this cycle, advances
    // the model over the coming posedge and returns at the next negedge.
    task automatic step();
        int              gid;
        logic [N-1:0]    e_ready, e_rv;
        logic [N*32-1:0] e_data;
        logic [31:0]     e_a, e_b;
        #1;
        for (int i = 0; i < N; i++)
            if (m_busy[i] && cyc == m_ready_at[i]) m_data[i] = m_res[i];
        e_rv = '0;
        for (int i = 0; i < N; i++) begin
            e_rv[i] = m_busy[i] && (cyc >= m_ready_at[i]);
            e_data[i*32 +: 32] = m_data[i];
        end
        gid = -1;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (gid < 0 && req_valid[j] && !m_busy[j]) gid = j;
        end
        e_ready = '0;
        e_a = '0;
        e_b = '0;
        if (gid >= 0) begin
            e_ready[gid] = 1'b1;
            e_a = req_a[gid*32 +: 32];
            e_b = req_b[gid*32 +: 32];
`ifdef FADD_ARB_FSUB_EN
            if (req_op[gid]) e_b[31] = ~e_b[31];
`endif
        end
        check_val("req_ready", req_ready, e_ready);
        check_val("fadd_en",   fadd_en, gid >= 0);
        check_val("fadd_a",    fadd_a, e_a);
        check_val("fadd_b",    fadd_b, e_b);
        check_val("rsp_valid", rsp_valid, e_rv);
        check_val("rsp_data",  rsp_data, e_data);
        if (gid >= 0) begin
            m_busy[gid] = 1'b1;
            m_ready_at[gid] = cyc + 4;
            m_res[gid] = f32_add(e_a, e_b);
            m_last = gid;
        end
        for (int i = 0; i < N; i++)
            if (e_rv[i] && rsp_ack[i]) m_busy[i] = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] ack, input int n);
        for (int c = 0; c < n; c++) begin
            req_valid = v;
            rsp_ack = ack;
            step();
        end
    endtask

    // ---------------- stimulus --------------------------------------------
    initial begin
        model_reset();
        // Reset values, with a request pending while reset is held.
        req_valid = '1;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_fadd_en",   fadd_en, 1'b0);
        check_val("rst_req_ready", req_ready, '0);
        check_val("rst_rsp_valid", rsp_valid, '0);
        check_val("rst_rsp_data",  rsp_data, '0);
        @(negedge clk);
        req_valid = '0;
        rstn = 1'b1;

        // 1) single add 1.0 + 2.0 from requester 0.
        req_a[31:0] = 32'h3F80_0000;
        req_b[31:0] = 32'h4000_0000;
        drive(3'b001, 3'b000, 1);
        drive(3'b000, 3'b000, 3);
        #1;
        check_val("t1_valid", rsp_valid[0], 1'b1);
        check_val("t1_data",  rsp_data[31:0], 32'h4040_0000);
        drive(3'b000, 3'b000, 3);
        drive(3'b000, 3'b001, 1);
        drive(3'b000, 3'b000, 2);

        // 2) two requesters re-requesting after every ack.
        for (int i = 0; i < N*32; i += 32) begin
            req_a[i +: 32] = rnd_fp();
            req_b[i +: 32] = rnd_fp();
        end
        drive(3'b011, 3'b011, 30);
        drive(3'b000, 3'b011, 6);

        // 3) back-to-back issues into different slices.
        req_a[31:0]  = rnd_fp(); req_b[31:0]  = rnd_fp();
        req_a[63:32] = rnd_fp(); req_b[63:32] = rnd_fp();
        drive(3'b011, 3'b000, 1);
        drive(3'b010, 3'b000, 1);
        drive(3'b000, 3'b000, 5);
        drive(3'b000, 3'b011, 1);
        drive(3'b000, 3'b000, 1);

        // 4) requester 0 parked in DONE, still requesting; requester 1 served.
        drive(3'b001, 3'b000, 1);
        drive(3'b000, 3'b000, 4);
        drive(3'b011, 3'b010, 12);
        drive(3'b000, 3'b011, 6);

        // 5) reset with two ops in flight.
        drive(3'b011, 3'b000, 2);
        req_valid = 3'b011;
        #2 rstn = 1'b0;
        #1;
        check_val("t5_rst_valid", rsp_valid, '0);
        check_val("t5_rst_data",  rsp_data, '0);
        check_val("t5_rst_en",    fadd_en, 1'b0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        model_reset();
        #1;
        check_val("t5_first_gnt", req_ready, 3'b001);
        drive(3'b011, 3'b000, 1);
        drive(3'b000, 3'b000, 7);
        drive(3'b000, 3'b011, 1);
        drive(3'b000, 3'b000, 1);

`ifdef FADD_ARB_FSUB_EN
        // 6) subtract: 3.0 - 1.0.
        req_a[31:0] = 32'h4040_0000;
        req_b[31:0] = 32'h3F80_0000;
        req_op = 3'b001;
        drive(3'b001, 3'b000, 1);
        req_op = 3'b000;
        drive(3'b000, 3'b000, 3);
        #1;
        check_val("t6_sub", rsp_data[31:0], 32'h4000_0000);
        drive(3'b000, 3'b001, 1);
        drive(3'b000, 3'b000, 1);
`endif

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N*32; i += 32) begin
                req_a[i +: 32] = rnd_fp();
                req_b[i +: 32] = rnd_fp();
            end
`ifdef FADD_ARB_FSUB_EN
            req_op = N'($urandom);
`endif
            req_valid = N'($urandom);
            rsp_ack = N'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
